muldiv_seq: RTL and testbench

MULDIV_SEQ -- requirements
Module: muldiv_seq

---
 rtl/muldiv_seq_if.sv | 22 ++
 rtl/muldiv_seq.sv | 158 +++++++++++++++
 tb/tb_muldiv_seq.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_seq_if
// Description : Request/response bundle for the sequential 4-bit
//               multiplier/divider. The master issues start/op/a/b and
//               observes busy/done/result/div0; the slave is the engine.
// Revision    : 1.0 - initial release
// ============================================================================
interface muldiv_seq_if;
    logic       start;
    logic       op;
    logic [3:0] a;
    logic [3:0] b;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic       div0;

    modport master (output start, op, a, b, input busy, done, result, div0);
    modport slave  (input start, op, a, b, output busy, done, result, div0);
endinterface
`default_nettype wire

// File: rtl/muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_seq
// Description : Sequential 4-bit unsigned multiply (shift-add) and divide
//               (restoring) sharing a single 4-bit ripple adder/subtractor.
//               Fixed latency: 4 iteration cycles plus one DONE cycle.
// Revision    : 1.0 - initial release
// ============================================================================

// One full-adder cell of the shared ripple adder.
module muldiv_seq_fa (
    input  wire logic a_i,
    input  wire logic b_i,
    input  wire logic c_i,
    output logic      s_o,
    output logic      c_o
);
    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module muldiv_seq (
    input  wire logic   clk,
    input  wire logic   rst,
    muldiv_seq_if.slave bus
);
    localparam logic [1:0] c_LAST_ITER = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic       op_q, op_d;
    // hi: multiply accumulator / divide partial remainder
    // lo: multiplier shift register / dividend-quotient shift register
    // opnd: multiplicand / divisor
    logic [3:0] hi_q, hi_d;
    logic [3:0] lo_q, lo_d;
    logic [3:0] opnd_q, opnd_d;
    logic [7:0] result_q, result_d;
    logic       div0_q, div0_d;
    logic       busy_d, done_d;

    logic       w_sub;
    logic [3:0] w_add_a;
    logic [3:0] w_add_b;
    logic [3:0] w_sum;
    logic [4:0] w_carry;
    logic       w_no_borrow;
    logic [4:0] w_mul_acc;

    // Shared adder: divide subtracts (inverted B, carry-in 1); divide feeds
    // the partial remainder already shifted left by one.
    assign w_sub      = op_q;
    assign w_add_a    = op_q ? {hi_q[2:0], lo_q[3]} : hi_q;
    assign w_add_b    = opnd_q ^ {4{w_sub}};
    assign w_carry[0] = w_sub;

    for (genvar i = 0; i < 4; i++) begin : g_fa
        muldiv_seq_fa u_fa (
            .a_i (w_add_a[i]),
            .b_i (w_add_b[i]),
            .c_i (w_carry[i]),
            .s_o (w_sum[i]),
            .c_o (w_carry[i+1])
        );
    end

    // A bit shifted out of the remainder's MSB means the shifted value is
    // >= 16 > divisor, so the subtraction must succeed even without carry-out.
    assign w_no_borrow = w_carry[4] | hi_q[3];
    assign w_mul_acc   = lo_q[0] ? {w_carry[4], w_sum} : {1'b0, hi_q};

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= 2'd0;
            op_q     <= 1'b0;
            hi_q     <= 4'd0;
            lo_q     <= 4'd0;
            opnd_q   <= 4'd0;
            result_q <= 8'h00;
            div0_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            opnd_q   <= opnd_d;
            result_q <= result_d;
            div0_q   <= div0_d;
        end
    end

    // FSM next state and status outputs decoded from the current state.
    always_comb begin
        state_d = state_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) state_d = S_ITER;
            end
            S_ITER: begin
                busy_d = 1'b1;
                if (cnt_q == c_LAST_ITER) state_d = S_DONE;
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Operand capture, one iteration per ITER cycle, result load on the last.
    always_comb begin
        cnt_d    = cnt_q;
        op_d     = op_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        opnd_d   = opnd_q;
        result_d = result_q;
        div0_d   = div0_q;
        if (state_q == S_IDLE && bus.start) begin
            cnt_d  = 2'd0;
            op_d   = bus.op;
            hi_d   = 4'd0;
            lo_d   = bus.op ? bus.a : bus.b;
            opnd_d = bus.op ? bus.b : bus.a;
        end else if (state_q == S_ITER) begin
            cnt_d = cnt_q + 2'd1;
            if (op_q) begin
                hi_d = w_no_borrow ? w_sum : w_add_a;
                lo_d = {lo_q[2:0], w_no_borrow};
            end else begin
                hi_d = w_mul_acc[4:1];
                lo_d = {w_mul_acc[0], lo_q[3:1]};
            end
            if (cnt_q == c_LAST_ITER) begin
                result_d = {hi_d, lo_d};
                div0_d   = op_q & (opnd_q == 4'd0);
            end
        end
    end

    assign bus.busy   = busy_d;
    assign bus.done   = done_d;
    assign bus.result = result_q;
    assign bus.div0   = div0_q;
endmodule
`default_nettype wire

// File: tb/tb_muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_seq
// Description : Self-checking bench for muldiv_seq. A transaction-level model
//               (accept -> 5-cycle latency -> result from plain arithmetic)
//               is compared with the DUT every cycle; directed cases pin
//               literal results, protocol behaviour and reset handling.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;

    muldiv_seq_if bus ();

    muldiv_seq u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_err    = 0;
    int         cyc      = 0;
    int         done_cnt = 0;
    int         ph       = 0;   // 0 idle, 1..4 in flight, 5 done cycle
    logic [7:0] m_res    = 8'h00;
    logic       m_div0   = 1'b0;
    logic [7:0] p_res    = 8'h00;
    logic       p_div0   = 1'b0;
    logic       prev_done = 1'b0;
    int         dq[$];

    // {div0, result} straight from unsigned arithmetic.
    function automatic logic [8:0] ref_op(input logic o, input logic [3:0] x, input logic [3:0] y);
        int xi, yi, p, q, rm;
        xi = int'(x);
        yi = int'(y);
        if (!o) begin
            p = xi * yi;
            return {1'b0, p[7:0]};
        end
        if (yi == 0) return {1'b1, x, 4'hF};
        q  = xi / yi;
        rm = xi % yi;
        return {1'b0, rm[3:0], q[3:0]};
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Advance one clock: update the model with the inputs present at the
    // edge, then compare every DUT output on the following falling edge.
    task automatic tick();
        logic [8:0] r;
        logic       e_busy, e_done;
        if (rst) begin
            ph = 0; m_res = 8'h00; m_div0 = 1'b0;
        end else begin
            case (ph)
                0: if (bus.start) begin
                    r = ref_op(bus.op, bus.a, bus.b);
                    p_div0 = r[8]; p_res = r[7:0]; ph = 1;
                end
                1, 2, 3: ph = ph + 1;
                4: begin ph = 5; m_res = p_res; m_div0 = p_div0; end
                default: ph = 0;
            endcase
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        e_busy = (ph >= 1 && ph <= 4);
        e_done = (ph == 5);
        chk("busy",   {7'd0, bus.busy}, {7'd0, e_busy});
        chk("done",   {7'd0, bus.done}, {7'd0, e_done});
        chk("result", bus.result, m_res);
        chk("div0",   {7'd0, bus.div0}, {7'd0, m_div0});
        if (bus.done === 1'b1) begin
            chk("done_single", {7'd0, prev_done}, 8'd0);
            done_cnt++;
            dq.push_back(cyc);
        end
        prev_done = bus.done;
    endtask

    // One operation from idle; checks latency and literal results.
    task automatic run_op(input logic o, input logic [3:0] x, input logic [3:0] y,
                          input logic [7:0] er, input logic ed);
        int n;
        bus.start = 1'b1; bus.op = o; bus.a = x; bus.b = y;
        tick();
        bus.start = 1'b0; bus.op = 1'($urandom); bus.a = 4'($urandom); bus.b = 4'($urandom);
        n = 1;
        while (bus.done !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("latency", 8'(n), 8'd5);
        chk("op_result", bus.result, er);
        chk("op_div0", {7'd0, bus.div0}, {7'd0, ed});
        tick();
    endtask

    initial begin
        int         d0;
        logic [8:0] r;
        logic       o;
        logic [3:0] x, y;

        // Reset with start asserted: reset wins, outputs cleared.
        rst = 1'b1; bus.start = 1'b1; bus.op = 1'b0; bus.a = 4'd3; bus.b = 4'd5;
        repeat (3) tick();
        chk("rst_busy",   {7'd0, bus.busy}, 8'd0);
        chk("rst_done",   {7'd0, bus.done}, 8'd0);
        chk("rst_result", bus.result, 8'h00);
        chk("rst_div0",   {7'd0, bus.div0}, 8'd0);
        rst = 1'b0; bus.start = 1'b0;
        tick();

        // Directed arithmetic cases.
        run_op(1'b0, 4'd13, 4'd11, 8'h8F, 1'b0);
        run_op(1'b0, 4'd15, 4'd15, 8'hE1, 1'b0);
        run_op(1'b0, 4'd0,  4'd9,  8'h00, 1'b0);
        run_op(1'b1, 4'd13, 4'd3,  8'h14, 1'b0);
        run_op(1'b1, 4'd2,  4'd7,  8'h20, 1'b0);
        run_op(1'b1, 4'd7,  4'd0,  8'h7F, 1'b1);
        run_op(1'b1, 4'd15, 4'd1,  8'h0F, 1'b0);

        // Start re-pulsed during ITER with other operands is ignored.
        d0 = done_cnt;
        bus.start = 1'b1; bus.op = 1'b0; bus.a = 4'd13; bus.b = 4'd11;
        tick();
        bus.start = 1'b0;
        repeat (2) tick();
        bus.start = 1'b1; bus.op = 1'b1; bus.a = 4'd5; bus.b = 4'd0;
        tick();
        bus.start = 1'b0;
        repeat (8) tick();
        chk("ignore_done_count", 8'(done_cnt - d0), 8'd1);
        chk("ignore_result", bus.result, 8'h8F);
        chk("ignore_div0", {7'd0, bus.div0}, 8'd0);

        // Start held for 12 cycles: two operations, done pulses 6 apart.
        dq.delete();
        bus.start = 1'b1; bus.op = 1'b0; bus.a = 4'd6; bus.b = 4'd7;
        repeat (12) tick();
        bus.start = 1'b0;
        repeat (3) tick();
        chk("held_done_count", 8'(dq.size()), 8'd2);
        if (dq.size() == 2) chk("held_spacing", 8'(dq[1] - dq[0]), 8'd6);
        chk("held_result", bus.result, 8'h2A);

        // Reset during the third ITER cycle aborts without a done pulse.
        d0 = done_cnt;
        bus.start = 1'b1; bus.op = 1'b0; bus.a = 4'd13; bus.b = 4'd11;
        tick();
        bus.start = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        chk("abort_busy", {7'd0, bus.busy}, 8'd0);
        chk("abort_result", bus.result, 8'h00);
        rst = 1'b0;
        run_op(1'b1, 4'd13, 4'd3, 8'h14, 1'b0);
        chk("abort_done_count", 8'(done_cnt - d0), 8'd1);

        // Random traffic: starts at any time, occasional reset.
        for (int i = 0; i < 300; i++) begin
            rst       = ($urandom_range(0, 39) == 0);
            bus.start = ($urandom_range(0, 2) == 0);
            bus.op    = 1'($urandom);
            bus.a     = 4'($urandom);
            bus.b     = 4'($urandom);
            tick();
        end
        rst = 1'b0; bus.start = 1'b0;
        repeat (6) tick();

        // Random single operations with literal-result checks.
        for (int i = 0; i < 30; i++) begin
            o = 1'($urandom);
            x = 4'($urandom);
            y = ($urandom_range(0, 5) == 0) ? 4'd0 : 4'($urandom);
            r = ref_op(o, x, y);
            run_op(o, x, y, r[7:0], r[8]);
            repeat ($urandom_range(0, 2)) tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end
endmodule
`default_nettype wire
